// File: rtl/systolic_pkg.sv
// Constants and types shared by the systolic array feeder and processing elements.
package systolic_pkg;

   localparam logic [1:0] CTRL_HOLD    = 2'b00;
   localparam logic [1:0] CTRL_LOAD    = 2'b01;
   localparam logic [1:0] CTRL_COMPUTE = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_COMPUTE,
      ST_DRAIN,
      ST_DONE
   } feeder_state_e;

endpackage

// File: rtl/skew_delay_line.sv
// Enable-gated delay line of DEPTH registers; one instance per array row builds the activation skew.
module skew_delay_line #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] stage_p [DEPTH];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) stage_p[i] <= '0;
      end else if (en) begin
         stage_p[0] <= din;
         for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
      end
   end

   assign dout = stage_p[DEPTH-1];

endmodule

// File: rtl/systolic_input_feeder.sv
// Upstream feeder of the weight-stationary array: loads weight rows, streams row-skewed
// activations under a global stall, then flushes the array and pulses done.
module systolic_input_feeder
   import systolic_pkg::*;
#(
   parameter int WORD_WIDTH = 8,
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   input  logic [CNT_WIDTH-1:0]         num_vectors,
   input  logic                         w_valid,
   output logic                         w_ready,
   input  logic [WORD_WIDTH*4*COLS-1:0] w_data,
   input  logic                         a_valid,
   output logic                         a_ready,
   input  logic [WORD_WIDTH*ROWS-1:0]   a_data,
   output logic [1:0]                   control,
   output logic [WORD_WIDTH*4*COLS-1:0] d_out,
   output logic [WORD_WIDTH*ROWS-1:0]   a_out,
   output logic                         busy,
   output logic                         done
);

   localparam int D_W     = WORD_WIDTH * 4 * COLS;
   localparam int BEAT_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int DRAIN_W = $clog2(ROWS + COLS);

   localparam logic [BEAT_W-1:0]    BEAT_ONE   = BEAT_W'(1);
   localparam logic [BEAT_W-1:0]    BEAT_LAST  = BEAT_W'(ROWS - 1);
   localparam logic [DRAIN_W-1:0]   DRAIN_ONE  = DRAIN_W'(1);
   localparam logic [DRAIN_W-1:0]   DRAIN_LAST = DRAIN_W'(ROWS + COLS - 2);
   localparam logic [CNT_WIDTH-1:0] VEC_ONE    = CNT_WIDTH'(1);

   feeder_state_e        state_q, state_n;
   logic [CNT_WIDTH-1:0] num_vec, num_n;
   logic [CNT_WIDTH-1:0] vec_cnt, vec_n;
   logic [BEAT_W-1:0]    beat_cnt, beat_n;
   logic [DRAIN_W-1:0]   drain_cnt, drain_n;
   logic [1:0]           control_n;
   logic [D_W-1:0]       d_out_n;
   logic                 w_ready_n, a_ready_n, busy_n, done_n;
   logic                 line_en, line_zero;

   always_comb begin
      state_n   = state_q;
      num_n     = num_vec;
      vec_n     = vec_cnt;
      beat_n    = beat_cnt;
      drain_n   = drain_cnt;
      control_n = CTRL_HOLD;
      d_out_n   = '0;
      w_ready_n = w_ready;
      a_ready_n = a_ready;
      busy_n    = busy;
      done_n    = 1'b0;
      line_en   = 1'b0;
      line_zero = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_n   = ST_LOAD;
               num_n     = num_vectors;
               vec_n     = '0;
               beat_n    = '0;
               drain_n   = '0;
               w_ready_n = 1'b1;
               busy_n    = 1'b1;
            end
         end
         ST_LOAD: begin
            d_out_n = d_out;
            if (w_valid && w_ready) begin
               d_out_n   = w_data;
               control_n = CTRL_LOAD;
               beat_n    = beat_cnt + BEAT_ONE;
               // Beats arrive bottom row first, so the last beat is the top row.
               if (beat_cnt == BEAT_LAST) begin
                  w_ready_n = 1'b0;
                  if (num_vec == '0) begin
                     state_n = ST_DRAIN;
                  end else begin
                     state_n   = ST_COMPUTE;
                     a_ready_n = 1'b1;
                  end
               end
            end
         end
         ST_COMPUTE: begin
            if (a_valid && a_ready) begin
               line_en   = 1'b1;
               control_n = CTRL_COMPUTE;
               vec_n     = vec_cnt + VEC_ONE;
               if (vec_cnt == num_vec - VEC_ONE) begin
                  a_ready_n = 1'b0;
                  state_n   = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            // Zeros push the last skewed lanes through every row and column.
            line_en   = 1'b1;
            line_zero = 1'b1;
            control_n = CTRL_COMPUTE;
            drain_n   = drain_cnt + DRAIN_ONE;
            if (drain_cnt == DRAIN_LAST) state_n = ST_DONE;
         end
         ST_DONE: begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         num_vec   <= '0;
         vec_cnt   <= '0;
         beat_cnt  <= '0;
         drain_cnt <= '0;
         control   <= CTRL_HOLD;
         d_out     <= '0;
         w_ready   <= 1'b0;
         a_ready   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         state_q   <= state_n;
         num_vec   <= num_n;
         vec_cnt   <= vec_n;
         beat_cnt  <= beat_n;
         drain_cnt <= drain_n;
         control   <= control_n;
         d_out     <= d_out_n;
         w_ready   <= w_ready_n;
         a_ready   <= a_ready_n;
         busy      <= busy_n;
         done      <= done_n;
      end
   end

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      logic [WORD_WIDTH-1:0] lane_in;
      assign lane_in = line_zero ? '0 : a_data[r*WORD_WIDTH +: WORD_WIDTH];

      skew_delay_line #(
         .WIDTH (WORD_WIDTH),
         .DEPTH (r + 1)
      ) u_skew (
         .clk   (clk),
         .reset (reset),
         .en    (line_en),
         .din   (lane_in),
         .dout  (a_out[r*WORD_WIDTH +: WORD_WIDTH])
      );
   end

endmodule

// File: tb/tb_systolic_input_feeder.sv
// Randomized and directed bench for systolic_input_feeder against an advance-history reference model.
module tb_systolic_input_feeder;
   import systolic_pkg::*;

   localparam int W  = 8;
   localparam int R  = 4;
   localparam int C  = 4;
   localparam int CW = 16;
   localparam int DW = W * 4 * C;
   localparam int AW = W * R;

   logic          clk = 1'b0;
   logic          reset, start, w_valid, a_valid;
   logic [CW-1:0] num_vectors;
   logic [DW-1:0] w_data;
   logic [AW-1:0] a_data;
   logic          w_ready, a_ready, busy, done;
   logic [1:0]    control;
   logic [DW-1:0] d_out;
   logic [AW-1:0] a_out;

   int checks = 0;
   int errors = 0;
   int edge_n = 0;

   // Every vector (or zero flush) pushed into the skew lines, oldest first.
   logic [AW-1:0] adv_q [$];

   systolic_input_feeder #(
      .WORD_WIDTH (W),
      .ROWS       (R),
      .COLS       (C),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .num_vectors (num_vectors),
      .w_valid     (w_valid),
      .w_ready     (w_ready),
      .w_data      (w_data),
      .a_valid     (a_valid),
      .a_ready     (a_ready),
      .a_data      (a_data),
      .control     (control),
      .d_out       (d_out),
      .a_out       (a_out),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_n++;

   // Runs one job; abort_mode 1 resets after two weight beats, 2 after one vector.
   task automatic run_job(input int num, input int pct, input int stall_at, input int abort_mode,
                          input bit directed, output int obs_load, output int obs_c10,
                          output int obs_ar, output int done_lat);
      int phase, beats, vecs, drains, last_acc;
      bit stalled, finished;
      logic [1:0] e_ctrl;
      logic [DW-1:0] e_d;
      logic [AW-1:0] e_a, tmp;
      bit e_wr, e_ar, e_busy, e_done;
      phase = 0; beats = 0; vecs = 0; drains = 0; last_acc = 0;
      stalled = 1'b0; finished = 1'b0;
      obs_load = 0; obs_c10 = 0; obs_ar = 0; done_lat = -1;
      e_ctrl = CTRL_HOLD; e_d = '0; e_wr = 1'b1; e_ar = 1'b0; e_busy = 1'b1; e_done = 1'b0;
      @(negedge clk);
      start = 1'b1;
      num_vectors = CW'(num);
      w_valid = 1'b0;
      a_valid = 1'b0;
      for (int guard = 0; guard < 4000 && !finished; guard++) begin
         @(negedge clk);
         e_a = '0;
         for (int r = 0; r < R; r++) begin
            if (adv_q.size() > r) begin
               tmp = adv_q[adv_q.size() - 1 - r];
               e_a[r*W +: W] = tmp[r*W +: W];
            end
         end
         checks += 7;
         if (control !== e_ctrl) begin errors++; $display("FAIL control t=%0d got %b want %b", edge_n, control, e_ctrl); end
         if (d_out !== e_d) begin errors++; $display("FAIL d_out t=%0d got %h want %h", edge_n, d_out, e_d); end
         if (a_out !== e_a) begin errors++; $display("FAIL a_out t=%0d got %h want %h", edge_n, a_out, e_a); end
         if (w_ready !== e_wr) begin errors++; $display("FAIL w_ready t=%0d got %b want %b", edge_n, w_ready, e_wr); end
         if (a_ready !== e_ar) begin errors++; $display("FAIL a_ready t=%0d got %b want %b", edge_n, a_ready, e_ar); end
         if (busy !== e_busy) begin errors++; $display("FAIL busy t=%0d got %b want %b", edge_n, busy, e_busy); end
         if (done !== e_done) begin errors++; $display("FAIL done t=%0d got %b want %b", edge_n, done, e_done); end
         if (control === CTRL_LOAD) obs_load++;
         if (control === CTRL_COMPUTE) obs_c10++;
         if (a_ready === 1'b1) obs_ar++;
         if (e_done) begin
            if (done === 1'b1) done_lat = edge_n - last_acc;
            finished = 1'b1;
         end else if ((abort_mode == 1 && phase == 0 && beats == 2) ||
                      (abort_mode == 2 && phase == 1 && vecs == 1)) begin
            #2 reset = 1'b1;
            #1;
            checks++;
            if ({control, d_out, a_out, w_ready, a_ready, busy, done} !== '0) begin
               errors++;
               $display("FAIL async_reset t=%0d got %h want 0", edge_n,
                        {control, d_out, a_out, w_ready, a_ready, busy, done});
            end
            start = 1'b0; w_valid = 1'b0; a_valid = 1'b0;
            #1 reset = 1'b0;
            adv_q.delete();
            finished = 1'b1;
         end else begin
            if (directed) begin
               start   = 1'b0;
               w_valid = (phase == 0);
               a_valid = (phase == 1) && !(vecs == stall_at && !stalled);
               if (phase == 1 && vecs == stall_at) stalled = 1'b1;
               w_data  = {16{8'(3 + beats)}};
               a_data  = {8'(4*vecs + 4), 8'(4*vecs + 3), 8'(4*vecs + 2), 8'(4*vecs + 1)};
            end else begin
               start   = ($urandom_range(0, 1) == 1) && phase < 3;
               w_valid = $urandom_range(0, 99) < pct;
               a_valid = $urandom_range(0, 99) < pct;
               w_data  = {$urandom, $urandom, $urandom, $urandom};
               a_data  = $urandom;
            end
            if (phase == 3) begin start = 1'b0; w_valid = 1'b0; a_valid = 1'b0; end
            case (phase)
               0: begin
                  if (w_valid) begin
                     e_ctrl = CTRL_LOAD; e_d = w_data; beats++; last_acc = edge_n + 1;
                     if (beats == R) begin
                        e_wr = 1'b0;
                        if (num == 0) phase = 2;
                        else begin phase = 1; e_ar = 1'b1; end
                     end
                  end else e_ctrl = CTRL_HOLD;
               end
               1: begin
                  e_d = '0;
                  if (a_valid) begin
                     e_ctrl = CTRL_COMPUTE; adv_q.push_back(a_data); vecs++; last_acc = edge_n + 1;
                     if (vecs == num) begin phase = 2; e_ar = 1'b0; end
                  end else e_ctrl = CTRL_HOLD;
               end
               2: begin
                  e_d = '0; e_ctrl = CTRL_COMPUTE; adv_q.push_back('0); drains++;
                  if (drains == R + C - 1) phase = 3;
               end
               default: begin
                  e_ctrl = CTRL_HOLD; e_done = 1'b1; e_busy = 1'b0;
               end
            endcase
         end
      end
      if (!finished) begin
         errors++;
         $display("FAIL job_timeout num=%0d got no done want done", num);
      end
   endtask

   task automatic test_reset();
      int ld, c10, ar, lat;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({control, d_out, a_out, w_ready, a_ready, busy, done} !== '0) begin
         errors++;
         $display("FAIL power_on_reset got %h want 0", {control, d_out, a_out, w_ready, a_ready, busy, done});
      end
      @(negedge clk) reset = 1'b0;
      run_job(3, 0, -1, 2, 1'b1, ld, c10, ar, lat);
      @(negedge clk);
      w_valid = 1'b1; a_valid = 1'b1;
      @(negedge clk);
      checks++;
      if ({w_ready, a_ready, busy, control} !== 5'b0) begin
         errors++;
         $display("FAIL idle_after_reset got %b want 00000", {w_ready, a_ready, busy, control});
      end
      w_valid = 1'b0; a_valid = 1'b0;
   endtask

   task automatic test_weight_load();
      int ld, c10, ar, lat;
      run_job(2, 0, -1, 0, 1'b1, ld, c10, ar, lat);
      checks += 2;
      if (ld != 4) begin errors++; $display("FAIL load_cycles got %0d want 4", ld); end
      if (lat != R + C) begin errors++; $display("FAIL load_done_latency got %0d want %0d", lat, R + C); end
   endtask

   task automatic test_skew();
      int ld, c10, ar, lat;
      run_job(1, 0, -1, 0, 1'b1, ld, c10, ar, lat);
      checks += 2;
      if (c10 != 1 + R + C - 1) begin errors++; $display("FAIL skew_compute_cycles got %0d want %0d", c10, R + C); end
      if (lat != R + C) begin errors++; $display("FAIL skew_done_latency got %0d want %0d", lat, R + C); end
   endtask

   task automatic test_stall();
      int ld, c10, ar, lat;
      run_job(3, 0, 1, 0, 1'b1, ld, c10, ar, lat);
      checks += 2;
      if (ar != 4) begin errors++; $display("FAIL stall_aready_cycles got %0d want 4", ar); end
      if (lat != R + C) begin errors++; $display("FAIL stall_done_latency got %0d want %0d", lat, R + C); end
   endtask

   task automatic test_empty();
      int ld, c10, ar, lat;
      run_job(0, 0, -1, 0, 1'b1, ld, c10, ar, lat);
      checks += 4;
      if (ld != 4) begin errors++; $display("FAIL empty_load_cycles got %0d want 4", ld); end
      if (c10 != R + C - 1) begin errors++; $display("FAIL empty_drain_cycles got %0d want %0d", c10, R + C - 1); end
      if (ar != 0) begin errors++; $display("FAIL empty_aready got %0d want 0", ar); end
      if (lat != R + C) begin errors++; $display("FAIL empty_done_latency got %0d want %0d", lat, R + C); end
   endtask

   task automatic test_abort_restart();
      int ld, c10, ar, lat;
      run_job(2, 0, -1, 1, 1'b1, ld, c10, ar, lat);
      run_job(2, 0, -1, 0, 1'b1, ld, c10, ar, lat);
      checks += 2;
      if (ld != 4) begin errors++; $display("FAIL restart_load_cycles got %0d want 4", ld); end
      if (lat != R + C) begin errors++; $display("FAIL restart_done_latency got %0d want %0d", lat, R + C); end
   endtask

   task automatic test_random();
      int ld, c10, ar, lat, num;
      for (int j = 0; j < 8; j++) begin
         num = $urandom_range(0, 7);
         run_job(num, $urandom_range(40, 90), -1, 0, 1'b0, ld, c10, ar, lat);
         checks += 2;
         if (ld != 4) begin errors++; $display("FAIL rand_load_cycles job=%0d got %0d want 4", j, ld); end
         if (lat != R + C) begin errors++; $display("FAIL rand_done_latency job=%0d got %0d want %0d", j, lat, R + C); end
      end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; num_vectors = '0;
      w_valid = 1'b0; a_valid = 1'b0; w_data = '0; a_data = '0;
      test_reset();
      test_weight_load();
      test_skew();
      test_stall();
      test_empty();
      test_abort_restart();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
